// File: rtl/snake_pkg.sv
// Shared snake-game definitions: direction encoding and the reversal test
// used by both the turn queue and the game logic controller.
package snake_pkg;

  localparam int DIR_W = 2;

  localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b01;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b10;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b11;

  // Same axis, different sense: the snake would reverse into itself.
  function automatic logic dir_is_opposite(input logic [DIR_W-1:0] a,
                                           input logic [DIR_W-1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/turn_request_queue.sv
// Small FIFO of direction requests applied one per snake move; owns the current direction.
// Build option TURN_QUEUE_BYPASS_EN: an accepted push on an empty queue during a move tick is applied immediately.
module turn_request_queue
  import snake_pkg::*;
#(
  parameter int                 DEPTH    = 4,
  parameter int                 PTR_BITS = 2,
  parameter logic [DIR_W-1:0]   INIT_DIR = DIR_RIGHT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  game_reset_in,
  input  logic [DIR_W-1:0]      direction_in,
  input  logic                  direction_valid_in,
  input  logic                  move_tick_in,
  output logic [DIR_W-1:0]      current_direction_out,
  output logic [PTR_BITS:0]     queue_count_out,
  output logic                  queue_full_out,
  output logic                  drop_pulse_out
);

  localparam logic [PTR_BITS:0]   CNT_ONE  = {{PTR_BITS{1'b0}}, 1'b1};
  localparam logic [PTR_BITS:0]   CNT_FULL = (PTR_BITS + 1)'(DEPTH);
  localparam logic [PTR_BITS-1:0] PTR_ONE  = {{(PTR_BITS - 1){1'b0}}, 1'b1};

  logic [DIR_W-1:0]    r_mem [DEPTH];
  logic [PTR_BITS-1:0] r_head;
  logic [PTR_BITS-1:0] r_tail;
  logic [PTR_BITS:0]   r_count;
  logic [DIR_W-1:0]    r_dir;
  logic                r_full;
  logic                r_drop;

  logic [PTR_BITS-1:0] w_last_idx;
  logic [DIR_W-1:0]    w_ref_dir;
  logic                w_empty;
  logic                w_is_full;
  logic                w_dup;
  logic                w_opp;
  logic                w_pop;
  logic                w_accept;
  logic                w_bypass;
  logic                w_push;
  logic                w_drop;
  logic [PTR_BITS:0]   w_count_nxt;

  assign w_last_idx = r_tail - PTR_ONE;
  assign w_empty    = (r_count == {(PTR_BITS + 1){1'b0}});
  assign w_is_full  = (r_count == CNT_FULL);
  assign w_ref_dir  = w_empty ? r_dir : r_mem[w_last_idx];

  // Classify the incoming request against the reference (pre-pop) direction.
  always_comb begin
    w_dup    = 1'b0;
    w_opp    = 1'b0;
    w_pop    = 1'b0;
    w_accept = 1'b0;
    w_drop   = 1'b0;
    w_pop    = move_tick_in & ~w_empty;
    if (direction_valid_in) begin
      w_dup    = (direction_in == w_ref_dir);
      w_opp    = dir_is_opposite(direction_in, w_ref_dir);
      w_accept = ~w_dup & ~w_opp & (~w_is_full | w_pop);
      w_drop   = ~w_dup & (w_opp | (w_is_full & ~w_pop));
    end else begin
      w_accept = 1'b0;
      w_drop   = 1'b0;
    end
  end

`ifdef TURN_QUEUE_BYPASS_EN
  assign w_bypass = w_accept & move_tick_in & w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_accept & ~w_bypass;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_ONE;
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Queue storage, pointers, applied direction and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DIR_W{1'b0}};
      end
      r_head  <= {PTR_BITS{1'b0}};
      r_tail  <= {PTR_BITS{1'b0}};
      r_count <= {(PTR_BITS + 1){1'b0}};
      r_dir   <= INIT_DIR;
      r_full  <= 1'b0;
      r_drop  <= 1'b0;
    end else if (game_reset_in) begin
      r_head  <= {PTR_BITS{1'b0}};
      r_tail  <= {PTR_BITS{1'b0}};
      r_count <= {(PTR_BITS + 1){1'b0}};
      r_dir   <= INIT_DIR;
      r_full  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= direction_in;
        r_tail        <= r_tail + PTR_ONE;
      end
      if (w_pop) begin
        r_dir  <= r_mem[r_head];
        r_head <= r_head + PTR_ONE;
      end else if (w_bypass) begin
        r_dir <= direction_in;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      r_drop  <= w_drop;
    end
  end

  assign current_direction_out = r_dir;
  assign queue_count_out       = r_count;
  assign queue_full_out        = r_full;
  assign drop_pulse_out        = r_drop;

endmodule

// File: tb/tb_turn_request_queue.sv
// Self-checking bench for turn_request_queue: directed scenarios plus a random
// run compared against a queue-based reference model.
module tb_turn_request_queue;

  logic       clk;
  logic       reset_n;
  logic       game_reset_in;
  logic [1:0] direction_in;
  logic       direction_valid_in;
  logic       move_tick_in;
  logic [1:0] current_direction_out;
  logic [2:0] queue_count_out;
  logic       queue_full_out;
  logic       drop_pulse_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [1:0] m_q[$];
  logic [1:0] m_dir;
  logic       m_drop;

  localparam logic [1:0] UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11;

  turn_request_queue dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .game_reset_in         (game_reset_in),
    .direction_in          (direction_in),
    .direction_valid_in    (direction_valid_in),
    .move_tick_in          (move_tick_in),
    .current_direction_out (current_direction_out),
    .queue_count_out       (queue_count_out),
    .queue_full_out        (queue_full_out),
    .drop_pulse_out        (drop_pulse_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic reverses(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b01;
  endfunction

  // Apply one cycle of stimulus and advance the model by the same clock edge.
  task automatic step(input logic gr, input logic v, input logic [1:0] d, input logic t);
    logic [1:0] ref_dir;
    int         pre_size;
    logic       popping;
    logic       accept;
    @(negedge clk);
    game_reset_in      = gr;
    direction_valid_in = v;
    direction_in       = d;
    move_tick_in       = t;
    @(posedge clk);
    if (gr) begin
      m_q.delete();
      m_dir  = RIGHT;
      m_drop = 1'b0;
    end else begin
      pre_size = m_q.size();
      ref_dir  = (pre_size > 0) ? m_q[pre_size - 1] : m_dir;
      popping  = t && (pre_size > 0);
      accept   = 1'b0;
      m_drop   = 1'b0;
      if (v && d != ref_dir) begin
        if (reverses(d, ref_dir)) m_drop = 1'b1;
        else if (pre_size == 4 && !popping) m_drop = 1'b1;
        else accept = 1'b1;
      end
      if (popping) m_dir = m_q.pop_front();
`ifdef TURN_QUEUE_BYPASS_EN
      if (accept && t && pre_size == 0) m_dir = d;
      else if (accept) m_q.push_back(d);
`else
      if (accept) m_q.push_back(d);
`endif
    end
    #1;
    game_reset_in      = 1'b0;
    direction_valid_in = 1'b0;
    move_tick_in       = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    game_reset_in = 1'b0; direction_in = UP; direction_valid_in = 1'b1; move_tick_in = 1'b1;
    m_q.delete(); m_dir = RIGHT; m_drop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (current_direction_out !== RIGHT) begin n_fail++; $display("FAIL reset_dir got=%0d exp=%0d", current_direction_out, RIGHT); end
    n_checks++; if (queue_count_out !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", queue_count_out); end
    n_checks++; if (queue_full_out !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", queue_full_out); end
    n_checks++; if (drop_pulse_out !== 1'b0) begin n_fail++; $display("FAIL reset_drop got=%b exp=0", drop_pulse_out); end
    direction_valid_in = 1'b0; move_tick_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_idle_ticks();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, UP, 1'b1);
      n_checks++; if (current_direction_out !== RIGHT || queue_count_out !== 3'd0 || drop_pulse_out !== 1'b0) begin
        n_fail++; $display("FAIL idle_tick dir=%0d cnt=%0d drop=%b exp dir=3 cnt=0 drop=0", current_direction_out, queue_count_out, drop_pulse_out);
      end
    end
  endtask

  task automatic test_sequence();
    step(1'b0, 1'b1, UP, 1'b0);
    n_checks++; if (queue_count_out !== 3'd1) begin n_fail++; $display("FAIL seq_cnt1 got=%0d exp=1", queue_count_out); end
    step(1'b0, 1'b1, LEFT, 1'b0);
    n_checks++; if (queue_count_out !== 3'd2 || current_direction_out !== RIGHT) begin n_fail++; $display("FAIL seq_cnt2 cnt=%0d dir=%0d exp cnt=2 dir=3", queue_count_out, current_direction_out); end
    step(1'b0, 1'b0, UP, 1'b1);
    n_checks++; if (queue_count_out !== 3'd1 || current_direction_out !== UP) begin n_fail++; $display("FAIL seq_tick1 cnt=%0d dir=%0d exp cnt=1 dir=0", queue_count_out, current_direction_out); end
    step(1'b0, 1'b0, UP, 1'b1);
    n_checks++; if (queue_count_out !== 3'd0 || current_direction_out !== LEFT) begin n_fail++; $display("FAIL seq_tick2 cnt=%0d dir=%0d exp cnt=0 dir=2", queue_count_out, current_direction_out); end
  endtask

  task automatic test_filter();
    step(1'b1, 1'b0, UP, 1'b0);
    step(1'b0, 1'b1, LEFT, 1'b0);
    n_checks++; if (drop_pulse_out !== 1'b1 || queue_count_out !== 3'd0) begin n_fail++; $display("FAIL reverse_drop drop=%b cnt=%0d exp drop=1 cnt=0", drop_pulse_out, queue_count_out); end
    step(1'b0, 1'b0, UP, 1'b0);
    n_checks++; if (drop_pulse_out !== 1'b0) begin n_fail++; $display("FAIL drop_one_cycle got=%b exp=0", drop_pulse_out); end
    step(1'b0, 1'b1, RIGHT, 1'b0);
    n_checks++; if (drop_pulse_out !== 1'b0 || queue_count_out !== 3'd0) begin n_fail++; $display("FAIL duplicate drop=%b cnt=%0d exp drop=0 cnt=0", drop_pulse_out, queue_count_out); end
  endtask

  task automatic test_full();
    logic [1:0] seq [4];
    seq[0] = UP; seq[1] = LEFT; seq[2] = DOWN; seq[3] = RIGHT;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, seq[i], 1'b0);
    n_checks++; if (queue_full_out !== 1'b1 || queue_count_out !== 3'd4) begin n_fail++; $display("FAIL fill full=%b cnt=%0d exp full=1 cnt=4", queue_full_out, queue_count_out); end
    step(1'b0, 1'b1, UP, 1'b0);
    n_checks++; if (drop_pulse_out !== 1'b1 || queue_count_out !== 3'd4) begin n_fail++; $display("FAIL full_drop drop=%b cnt=%0d exp drop=1 cnt=4", drop_pulse_out, queue_count_out); end
    step(1'b0, 1'b1, UP, 1'b1);
    n_checks++; if (drop_pulse_out !== 1'b0 || queue_count_out !== 3'd4 || queue_full_out !== 1'b1 || current_direction_out !== UP) begin
      n_fail++; $display("FAIL full_push_pop drop=%b cnt=%0d full=%b dir=%0d exp drop=0 cnt=4 full=1 dir=0", drop_pulse_out, queue_count_out, queue_full_out, current_direction_out);
    end
  endtask

  task automatic test_game_reset();
    step(1'b1, 1'b0, UP, 1'b0);
    step(1'b0, 1'b1, UP, 1'b0);
    step(1'b0, 1'b1, LEFT, 1'b0);
    step(1'b0, 1'b1, DOWN, 1'b0);
    n_checks++; if (queue_count_out !== 3'd3) begin n_fail++; $display("FAIL gr_setup cnt=%0d exp=3", queue_count_out); end
    step(1'b1, 1'b1, UP, 1'b1);
    n_checks++; if (queue_count_out !== 3'd0 || current_direction_out !== RIGHT || drop_pulse_out !== 1'b0 || queue_full_out !== 1'b0) begin
      n_fail++; $display("FAIL game_reset cnt=%0d dir=%0d drop=%b full=%b exp cnt=0 dir=3 drop=0 full=0", queue_count_out, current_direction_out, drop_pulse_out, queue_full_out);
    end
  endtask

  task automatic test_empty_push_tick();
    step(1'b0, 1'b1, UP, 1'b1);
`ifdef TURN_QUEUE_BYPASS_EN
    n_checks++; if (current_direction_out !== UP || queue_count_out !== 3'd0) begin n_fail++; $display("FAIL bypass dir=%0d cnt=%0d exp dir=0 cnt=0", current_direction_out, queue_count_out); end
`else
    n_checks++; if (current_direction_out !== RIGHT || queue_count_out !== 3'd1) begin n_fail++; $display("FAIL enqueue dir=%0d cnt=%0d exp dir=3 cnt=1", current_direction_out, queue_count_out); end
    step(1'b0, 1'b0, UP, 1'b1);
    n_checks++; if (current_direction_out !== UP || queue_count_out !== 3'd0) begin n_fail++; $display("FAIL enqueue_apply dir=%0d cnt=%0d exp dir=0 cnt=0", current_direction_out, queue_count_out); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      n_checks++;
      if (current_direction_out !== m_dir || queue_count_out !== 3'(m_q.size()) ||
          queue_full_out !== (m_q.size() == 4) || drop_pulse_out !== m_drop) begin
        n_fail++;
        $display("FAIL random[%0d] dir=%0d cnt=%0d full=%b drop=%b exp dir=%0d cnt=%0d full=%b drop=%b", i,
                 current_direction_out, queue_count_out, queue_full_out, drop_pulse_out,
                 m_dir, m_q.size(), (m_q.size() == 4), m_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_ticks();
    test_sequence();
    test_filter();
    test_full();
    test_game_reset();
    test_empty_push_tick();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
